// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings, tag nibble and
// the 9600-baud 8E1 frame timing used alongside the UART.
package uart_tx_arbiter_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StArb    = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StTag    = 3'd3;
    localparam logic [2:0] StIssue  = 3'd4;
    localparam logic [2:0] StWaitLo = 3'd5;
    localparam logic [2:0] StWaitHi = 3'd6;

    localparam logic [3:0] TagHi = 4'hA;

    localparam int unsigned ClkHz      = 25_000_000;
    localparam int unsigned Baud       = 9600;
    localparam int unsigned ClksPerBit = ClkHz / Baud;
    // start + 8 data + even parity + stop
    localparam int unsigned FrameBits  = 11;
    localparam int unsigned FrameClks  = ClksPerBit * FrameBits;

    function automatic logic [7:0] tag_byte(input logic [2:0] k);
        return {TagHi, 1'b0, k};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping
// N-1 -> 0. The pointer register lives in the parent.
module uart_tx_arbiter_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % N);
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte-stream requesters,
// grant held per packet. Define UART_ARB_TAG_EN to prefix each grant with a tag byte.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BYTES = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [7:0]     t_data,
    output logic           t_valid,
    input  logic           t_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0]  CntLast = 8'(MAX_BYTES - 1);

    logic [2:0]      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      t_data_q, t_data_d;
    logic            last_q, last_d;

    logic [N-1:0]    pick_gnt;
    logic [IdxW-1:0] pick_idx;
    logic            pick_any;
    logic            owner_valid;
    logic            owner_last;
    logic [7:0]      owner_data;

    uart_tx_arbiter_rr_arbiter #(
        .N    (N),
        .IdxW (IdxW)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign owner_valid = req_valid[idx_q];
    assign owner_last  = req_last[idx_q];
    assign owner_data  = req_data[{idx_q, 3'b000} +: 8];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        t_data_d = t_data_q;
        last_d   = last_q;
        case (state_q)
            StIdle: begin
                if (|req_valid) state_d = StArb;
            end
            StArb: begin
                // Requests can vanish between IDLE and ARB; fall back rather than grant nobody.
                if (pick_any) begin
                    grant_d = pick_gnt;
                    idx_d   = pick_idx;
`ifdef UART_ARB_TAG_EN
                    state_d = StTag;
`else
                    state_d = StLoad;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
`ifdef UART_ARB_TAG_EN
            StTag: begin
                t_data_d = tag_byte(3'(idx_q));
                last_d   = 1'b0;
                state_d  = StIssue;
            end
`endif
            StLoad: begin
                if (owner_valid) begin
                    t_data_d = owner_data;
                    last_d   = owner_last | (cnt_q == CntLast);
                    cnt_d    = cnt_q + 8'd1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (t_ready) state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!t_ready) state_d = StWaitHi;
            end
            StWaitHi: begin
                if (t_ready) begin
                    if (last_q) begin
                        grant_d = '0;
                        cnt_d   = '0;
                        ptr_d   = (idx_q == IdxW'(N - 1)) ? '0 : idx_q + IdxW'(1);
                        state_d = StIdle;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            t_data_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            t_data_q <= t_data_d;
            last_q   <= last_d;
        end
    end

    assign req_ready = (state_q == StLoad) ? (grant_q & req_valid) : '0;
    assign t_valid   = (state_q == StIssue) & t_ready;
    assign t_data    = t_data_q;
    assign grant     = grant_q;
    assign busy      = (|grant_q) | (state_q == StIssue) | (state_q == StWaitLo) |
                       (state_q == StWaitHi);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int MaxBytes = 16;
`ifdef UART_ARB_TAG_EN
    localparam bit TagEn = 1'b1;
`else
    localparam bit TagEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     t_data;
    logic           t_valid;
    logic           t_ready;
    logic [N-1:0]   grant;
    logic           busy;

    always #20 clk = ~clk;

    uart_tx_arbiter #(
        .N         (N),
        .MAX_BYTES (MaxBytes)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .t_data    (t_data),
        .t_valid   (t_valid),
        .t_ready   (t_ready),
        .grant     (grant),
        .busy      (busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_cnt[N];
    logic [8:0]  rq[N][$];   // requester stimulus {last, data}
    logic [8:0]  mq[N][$];   // model copy of the same traffic
    logic [10:0] exp_q[$];   // expected UART bytes {owner, data}
    int          m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic expect_start(input int k);
        if (TagEn) exp_q.push_back({3'(k), 4'hA, 1'b0, 3'(k)});
    endtask

    task automatic expect_byte(input int k, input logic [7:0] b);
        exp_q.push_back({3'(k), b});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && grant == '0 && t_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n >= budget), 0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check({name, "_rst_grant"}, 32'(grant), 0);
        check({name, "_rst_req_ready"}, 32'(req_ready), 0);
        check({name, "_rst_t_valid"}, 32'(t_valid), 0);
        check({name, "_rst_t_data"}, 32'(t_data), 0);
        check({name, "_rst_busy"}, 32'(busy), 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Requester side: pop on a completed transfer, then present the next queued byte.
    initial begin
        logic [N-1:0] xfer;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            xfer = req_ready & req_valid;
            @(posedge clk);
            if (!rstn) xfer = '0;
            #1;
            for (int i = 0; i < N; i++) begin
                if (xfer[i] && rq[i].size() != 0) void'(rq[i].pop_front());
                req_valid[i] = (rq[i].size() != 0);
                if (rq[i].size() != 0) {req_last[i], req_data[8*i +: 8]} = rq[i][0];
            end
        end
    end

    // UART: drops ready 1-2 cycles after the issue pulse, frame lasts a random short time.
    initial begin
        t_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (t_valid) begin
                repeat ($urandom_range(2, 1)) @(posedge clk);
                #1 t_ready = 1'b0;
                repeat ($urandom_range(10, 2)) @(posedge clk);
                #1 t_ready = 1'b1;
            end
        end
    end

    // Per-cycle compare process.
    initial begin
        logic [10:0] e;
        logic        hold;
        logic        seen_lo;
        logic [7:0]  held;
        hold    = 1'b0;
        seen_lo = 1'b0;
        held    = '0;
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        forever begin
            @(negedge clk);
            check("t_valid_without_t_ready", 32'(t_valid & ~t_ready), 0);
            check("req_ready_onehot0", 32'($onehot0(req_ready)), 1);
            check("grant_onehot0", 32'($onehot0(grant)), 1);
            check("req_ready_outside_grant", 32'(req_ready & ~grant), 0);
            for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) rdy_cnt[i]++;
            if (!rstn) begin
                hold = 1'b0;
            end else if (hold) begin
                check("t_data_held_during_frame", 32'(t_data), 32'(held));
                if (!t_ready) seen_lo = 1'b1;
                else if (seen_lo) hold = 1'b0;
            end
            if (t_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_uart_byte: got 0x%0h, expected no byte at %0t",
                             t_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("uart_byte", 32'(t_data), 32'(e[7:0]));
                    check("grant_owner", 32'(grant), 32'(1) << e[10:8]);
                    check("busy_on_issue", 32'(busy), 1);
                end
                held    = t_data;
                hold    = 1'b1;
                seen_lo = 1'b0;
            end
        end
    end

    initial begin
        #(40 * 95000);
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int lat;
        int n;
        int k;
        int cnt;
        logic [8:0] x;
        logic [7:0] d;

        rstn = 1'b0;
        #1;
        check("reset_grant", 32'(grant), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_t_valid", 32'(t_valid), 0);
        check("reset_t_data", 32'(t_data), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Single packet from requester 0.
        @(negedge clk);
        #2;
        r0 = rdy_cnt[0];
        push(0, 8'h5A, 1'b0);
        push(0, 8'hA5, 1'b1);
        expect_start(0);
        expect_byte(0, 8'h5A);
        expect_byte(0, 8'hA5);
        @(negedge clk);
        lat = 0;
        while (!req_ready[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
`ifndef UART_ARB_TAG_EN
        check("first_req_ready_latency", 32'(lat), 2);
`endif
        wait_drain("single_packet", 2000);
        check("req_ready0_pulses", 32'(rdy_cnt[0] - r0), 2);

        // Contention from pointer 0: order 10,11,12,13.
        do_reset("pre_contention");
        @(negedge clk);
        #2;
        for (int i = 0; i < N; i++) push(i, 8'(8'h10 + i), 1'b1);
        for (int i = 0; i < N; i++) begin
            expect_start(i);
            expect_byte(i, 8'(8'h10 + i));
        end
        wait_drain("contention", 4000);

        // Pointer is back at 0, so requester 1 precedes requester 3.
        @(negedge clk);
        #2;
        push(3, 8'h13, 1'b1);
        push(1, 8'h11, 1'b1);
        expect_start(1);
        expect_byte(1, 8'h11);
        expect_start(3);
        expect_byte(3, 8'h13);
        wait_drain("rotation", 2000);

        // Cap: 20 unterminated bytes from requester 2, requester 1 joins once 2 holds the grant.
        @(negedge clk);
        #2;
        for (int i = 0; i < 20; i++) push(2, 8'(i), 1'b0);
        expect_start(2);
        for (int i = 0; i < 16; i++) expect_byte(2, 8'(i));
        expect_start(1);
        expect_byte(1, 8'hE0);
        expect_byte(1, 8'hE1);
        expect_start(2);
        for (int i = 16; i < 20; i++) expect_byte(2, 8'(i));
        n = 0;
        while (grant !== 4'b0100 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cap_grant_req2", 32'(grant), 32'h4);
        #2;
        push(1, 8'hE0, 1'b0);
        push(1, 8'hE1, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check("cap_sequence_timeout", 32'(n >= 8000), 0);

        // Owner has no more bytes and no last: it must stall holding the grant.
        repeat (16) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            check("stall_grant", 32'(grant), 32'h4);
            check("stall_no_t_valid", 32'(t_valid), 0);
            check("stall_no_req_ready", 32'(req_ready), 0);
            check("stall_busy", 32'(busy), 1);
            @(negedge clk);
        end
        do_reset("stall");

        // Recovery after reset: pointer restarts at 0.
        @(negedge clk);
        #2;
        push(0, 8'h77, 1'b0);
        push(0, 8'h78, 1'b1);
        expect_start(0);
        expect_byte(0, 8'h77);
        expect_byte(0, 8'h78);
        wait_drain("recovery", 2000);

        // Single byte from requester 2 (preceded by tag 0xA2 when tagging is built in).
        @(negedge clk);
        #2;
        push(2, 8'h33, 1'b1);
        expect_start(2);
        expect_byte(2, 8'h33);
        wait_drain("req2_single", 2000);

        // Last grant went to requester 2, so the next search starts at 3.
        m_ptr = 3;
        for (int round = 0; round < 4; round++) begin
            @(negedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < int'($urandom_range(2, 0)); p++) begin
                    n = int'($urandom_range(20, 1));
                    for (int b = 0; b < n; b++) begin
                        d = 8'($urandom);
                        push(i, d, b == n - 1);
                        mq[i].push_back({b == n - 1, d});
                    end
                end
            end
            while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0) begin
                k = -1;
                for (int j = 0; j < N; j++) begin
                    if (k < 0 && mq[(m_ptr + j) % N].size() != 0) k = (m_ptr + j) % N;
                end
                expect_start(k);
                cnt = 0;
                do begin
                    x = mq[k].pop_front();
                    expect_byte(k, x[7:0]);
                    cnt++;
                end while (!x[8] && cnt < MaxBytes);
                m_ptr = (k + 1) % N;
            end
            wait_drain("random_round", 20000);
        end

        repeat (5) @(negedge clk);
        check("end_grant_idle", 32'(grant), 0);
        check("end_not_busy", 32'(busy), 0);
        check("end_expected_left", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
